// File: rtl/bp_pkg.sv
// Shared widths and the entry format for the branch resolve queue.
package bp_pkg;
  localparam int BP_IDX_W   = 10;
  localparam int BP_Q_DEPTH = 4;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;
endpackage

// File: rtl/bp_entry_fifo.sv
// In-flight branch storage: circular entry array with head/tail/count control.
// clear has priority over push/pop and collapses the queue to empty.
module bp_entry_fifo import bp_pkg::*; #(
  parameter int DEPTH = BP_Q_DEPTH,
  parameter int IDX_W = BP_IDX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_pred,
  input  logic             pop_en,
  input  logic             clear,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_pred,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] idx_mem  [DEPTH];
  logic             pred_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (push_en) begin
      idx_mem[tail_q]  <= push_idx;
      pred_mem[tail_q] <= push_pred;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) tail_d = tail_q + PTR_W'(1);
      if (pop_en)  head_d = head_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_idx  = idx_mem[head_q];
  assign head_pred = pred_mem[head_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/bp_resolve_queue.sv
// Tracks predicted branches from fetch to execute and emits a registered
// predictor-update pulse per resolve; a mispredict squashes all younger entries.
module bp_resolve_queue import bp_pkg::*; #(
  parameter int DEPTH = BP_Q_DEPTH,
  parameter int IDX_W = BP_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [IDX_W-1:0]         push_idx,
  input  logic                     push_pred,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     write,
  output logic [IDX_W-1:0]         actual_outcome_idx,
  output logic                     actual_outcome,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic             res_acc, mis_now, push_acc, pop_en, clear;

  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             outcome_q, outcome_d;
  logic             mis_q, mis_d;

  // Head is only meaningful when non-empty, so the compare is gated by res_acc.
  assign res_acc  = resolve & ~empty & ~flush;
  assign mis_now  = res_acc & (head_pred != resolve_taken);
  assign push_acc = push & ~full & ~flush & ~mis_now;
  assign pop_en   = res_acc & ~mis_now;
  assign clear    = flush | mis_now;

  bp_entry_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_en   (push_acc),
    .push_idx  (push_idx),
    .push_pred (push_pred),
    .pop_en    (pop_en),
    .clear     (clear),
    .head_idx  (head_idx),
    .head_pred (head_pred),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    write_d   = 1'b0;
    idx_d     = '0;
    outcome_d = 1'b0;
    mis_d     = 1'b0;
    if (res_acc) begin
      write_d   = 1'b1;
      idx_d     = head_idx;
      outcome_d = resolve_taken;
      mis_d     = mis_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q   <= 1'b0;
      idx_q     <= '0;
      outcome_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      write_q   <= write_d;
      idx_q     <= idx_d;
      outcome_q <= outcome_d;
      mis_q     <= mis_d;
    end
  end

  assign write              = write_q;
  assign actual_outcome_idx = idx_q;
  assign actual_outcome     = outcome_q;
  assign mispredict         = mis_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: expected write pulses are queued at
// resolve time and matched by an independent monitor on the falling edge.
module tb_bp_resolve_queue;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, push_pred, resolve, resolve_taken, flush;
  logic [9:0]  push_idx;
  logic        write, actual_outcome, mispredict, full, empty;
  logic [9:0]  actual_outcome_idx;
  logic [2:0]  count;

  typedef struct {
    bp_entry_t ent;
    logic      outcome;
    logic      mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bp_resolve_queue #(.DEPTH(4), .IDX_W(10)) dut (
    .clk                (clk),
    .rst                (rst),
    .push               (push),
    .push_idx           (push_idx),
    .push_pred          (push_pred),
    .resolve            (resolve),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .write              (write),
    .actual_outcome_idx (actual_outcome_idx),
    .actual_outcome     (actual_outcome),
    .mispredict         (mispredict),
    .full               (full),
    .empty              (empty),
    .count              (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    push    = 1'b0;
    resolve = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic drive_push(input logic [9:0] idx, input logic pred);
    push      = 1'b1;
    push_idx  = idx;
    push_pred = pred;
  endtask

  // track=0 means the pulse is checked inline (e.g. cut short by reset).
  task automatic drive_resolve(input logic taken, input logic [9:0] exp_idx,
                               input logic exp_mis, input bit track);
    exp_t e;
    resolve       = 1'b1;
    resolve_taken = taken;
    if (track) begin
      e.ent.idx  = exp_idx;
      e.ent.pred = taken ^ exp_mis;
      e.outcome  = taken;
      e.mis      = exp_mis;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        chk("write_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_idx", int'(actual_outcome_idx), int'(e.ent.idx));
          chk("write_outcome", int'(actual_outcome), int'(e.outcome));
          chk("write_mispredict", int'(mispredict), int'(e.mis));
        end
      end else begin
        chk("idle_idx_zero", int'(actual_outcome_idx), 0);
        chk("idle_flags_zero", int'({actual_outcome, mispredict}), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; push = 1'b0; push_idx = '0; push_pred = 1'b0;
    resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_write", int'(write), 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single push then resolve
    drive_push(10'h005, 1'b1); step();
    drive_resolve(1'b1, 10'h005, 1'b0, 1'b1); step();
    step();
    chk("single_empty", int'(empty), 1);

    // Fill to full, overflow push ignored, drain in order
    drive_push(10'h001, 1'b0); step();
    drive_push(10'h002, 1'b1); step();
    drive_push(10'h003, 1'b1); step();
    drive_push(10'h004, 1'b0); step();
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    drive_push(10'h3FF, 1'b1); step();
    chk("overflow_count", int'(count), 4);
    drive_resolve(1'b0, 10'h001, 1'b0, 1'b1); step();
    drive_resolve(1'b1, 10'h002, 1'b0, 1'b1); step();
    drive_resolve(1'b1, 10'h003, 1'b0, 1'b1); step();
    drive_resolve(1'b0, 10'h004, 1'b0, 1'b1); step();
    step();
    chk("drain_empty", int'(empty), 1);
    drive_push(10'h020, 1'b1); step();
    drive_resolve(1'b1, 10'h020, 1'b0, 1'b1); step();
    drive_push(10'h021, 1'b0); step();
    drive_resolve(1'b0, 10'h021, 1'b0, 1'b1); step();
    drive_push(10'h022, 1'b1); step();
    drive_resolve(1'b1, 10'h022, 1'b0, 1'b1); step();
    chk("wrap_count", int'(count), 0);

    // Mispredict squashes queue and drops same-cycle push
    drive_push(10'h010, 1'b1); step();
    drive_push(10'h011, 1'b0); step();
    drive_resolve(1'b0, 10'h010, 1'b1, 1'b1);
    drive_push(10'h012, 1'b1); step();
    chk("mispred_count", int'(count), 0);
    chk("mispred_empty", int'(empty), 1);

    // Resolve while empty: nothing happens
    drive_resolve(1'b1, 10'h000, 1'b0, 1'b0); step();
    chk("empty_res_write", int'(write), 0);
    chk("empty_res_count", int'(count), 0);

    // Simultaneous push and correct resolve at count 2
    drive_push(10'h030, 1'b1); step();
    drive_push(10'h031, 1'b0); step();
    drive_push(10'h032, 1'b1);
    drive_resolve(1'b1, 10'h030, 1'b0, 1'b1); step();
    chk("pushres_count", int'(count), 2);
    drive_resolve(1'b0, 10'h031, 1'b0, 1'b1); step();
    drive_resolve(1'b1, 10'h032, 1'b0, 1'b1); step();
    chk("pushres_empty", int'(empty), 1);

    // Flush with same-cycle resolve
    drive_push(10'h040, 1'b1); step();
    drive_push(10'h041, 1'b0); step();
    drive_push(10'h042, 1'b1); step();
    chk("preflush_count", int'(count), 3);
    flush = 1'b1;
    drive_resolve(1'b1, 10'h040, 1'b0, 1'b0); step();
    chk("flush_count", int'(count), 0);
    chk("flush_write", int'(write), 0);
    step();

    // Reset one cycle after a resolve cancels the pending pulse
    drive_push(10'h050, 1'b1); step();
    drive_push(10'h051, 1'b1); step();
    drive_resolve(1'b1, 10'h050, 1'b0, 1'b0); step();
    chk("prereset_write", int'(write), 1);
    chk("prereset_idx", int'(actual_outcome_idx), 10'h050);
    rst = 1'b1;
    #1;
    chk("midrst_write", int'(write), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_count", int'(count), 0);
    step(); step();
    rst = 1'b0;
    step(); step();

    chk("leftover_expect", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
